return_stack_ctrl: RTL and testbench

// - Hardware return-address stack serving the single-cycle MIPS-style core.
// - The instruction controller issues stack_push on jsb and stack_pop on ret.
// - On jsb, this block stores the return PC.
// - On ret, it presents the current top as top_addr; the PC mux selects it when pc_src=2'b10.
// - Owns pointer/occupancy bookkeeping, full/empty status and sticky overflow/underflow error flags.

---
 rtl/return_stack_ctrl.sv | 107 ++++++++++
 tb/tb_return_stack_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/return_stack_ctrl.sv
// Hardware return-address stack: circular register array with occupancy, full/empty and sticky error flags.
// Optional macro RETURN_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module return_stack_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            top_addr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              wr_en;

  assign top_idx   = sp_q - PTR_ONE;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top_addr  = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q  & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    wr_en       = 1'b0;
    wr_idx      = sp_q;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          sp_d    = sp_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
          // sp doubles as the oldest slot when full, so overwrite there and advance
          wr_en = 1'b1;
          sp_d  = sp_q + PTR_ONE;
`endif
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_d    = sp_q - PTR_ONE;
          count_d = count_q - CNT_ONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!empty) begin
          wr_idx = top_idx;
        end else begin
          sp_d        = sp_q + PTR_ONE;
          count_d     = count_q + CNT_ONE;
          underflow_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_addr;
  end

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Self-checking bench for return_stack_ctrl using a queue-based stack model and an expected-result scoreboard.
module tb_return_stack_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [ADDR_W-1:0] top;
    logic [3:0]        cnt;
    logic              emp;
    logic              ful;
    logic              ov;
    logic              un;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] top_addr;
  logic [3:0]        count;
  logic              empty, full, overflow, underflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [ADDR_W-1:0] stk[$];
  logic              m_ov = 1'b0;
  logic              m_un = 1'b0;
  exp_t              exp_q[$];

  return_stack_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .err_clr(err_clr), .top_addr(top_addr), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] model_top();
    return (stk.size() == 0) ? '0 : stk[$];
  endfunction

  function automatic void model_step(input logic p, input logic q, input logic [ADDR_W-1:0] a, input logic c);
    if (c) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (p && !q) begin
      if (stk.size() < DEPTH) stk.push_back(a);
      else begin
        m_ov = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(a);
`endif
      end
    end else if (!p && q) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_un = 1'b1;
    end else if (p && q) begin
      if (stk.size() > 0) stk[stk.size()-1] = a;
      else begin
        stk.push_back(a);
        m_un = 1'b1;
      end
    end
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.top = model_top();
    e.cnt = 4'(stk.size());
    e.emp = (stk.size() == 0);
    e.ful = (stk.size() == DEPTH);
    e.ov  = m_ov;
    e.un  = m_un;
    return e;
  endfunction

  task automatic do_cycle(input logic p, input logic q, input logic [ADDR_W-1:0] a, input logic c);
    exp_t e;
    @(negedge clk);
    push = p; pop = q; push_addr = a; err_clr = c;
    #1;
    check_eq("pre_top", 32'(top_addr), 32'(model_top()));
    model_step(p, q, a, c);
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("top",       32'(top_addr),  32'(e.top));
    check_eq("count",     32'(count),     32'(e.cnt));
    check_eq("empty",     32'(empty),     32'(e.emp));
    check_eq("full",      32'(full),      32'(e.ful));
    check_eq("overflow",  32'(overflow),  32'(e.ov));
    check_eq("underflow", 32'(underflow), 32'(e.un));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, 32'(count),     32'd0);
    check_eq({tag, "_empty"}, 32'(empty),     32'd1);
    check_eq({tag, "_top"},   32'(top_addr),  32'd0);
    check_eq({tag, "_ov"},    32'(overflow),  32'd0);
    check_eq({tag, "_un"},    32'(underflow), 32'd0);
  endtask

  // Async reset pulse placed strictly between clock edges.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state(tag);
    #1 rst = 1'b0;
    stk.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  initial begin
    logic p, q;
    int unsigned r;

    repeat (2) @(posedge clk);
    #1 check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run
    do_cycle(1, 0, 12'h010, 0);
    do_cycle(1, 0, 12'h020, 0);
    pulse_reset("midrst");

    // LIFO order
    do_cycle(1, 0, 12'h101, 0);
    do_cycle(1, 0, 12'h202, 0);
    do_cycle(1, 0, 12'h303, 0);
    do_cycle(0, 1, 12'h000, 0);
    do_cycle(0, 1, 12'h000, 0);
    do_cycle(0, 1, 12'h000, 0);
    do_cycle(0, 0, 12'h000, 0);

    // Fill and push while full
    pulse_reset("rst3");
    for (int k = 1; k <= DEPTH; k++) do_cycle(1, 0, 12'(k * 'h11), 0);
    do_cycle(1, 0, 12'hAAA, 0);
    for (int k = 0; k < DEPTH; k++) do_cycle(0, 1, 12'h000, 0);

    // Underflow and sticky clear
    pulse_reset("rst4");
    do_cycle(0, 1, 12'h000, 0);
    do_cycle(0, 0, 12'h000, 1);
    do_cycle(0, 1, 12'h000, 1);

    // Simultaneous push & pop: mid, full, empty
    pulse_reset("rst5");
    do_cycle(1, 0, 12'h011, 0);
    do_cycle(1, 0, 12'h033, 0);
    do_cycle(1, 0, 12'h055, 0);
    do_cycle(1, 1, 12'h077, 0);
    for (int k = 0; k < DEPTH - 3; k++) do_cycle(1, 0, 12'(12'h100 + k), 0);
    do_cycle(1, 1, 12'h099, 0);
    pulse_reset("rst5b");
    do_cycle(1, 1, 12'h077, 0);

    // Pointer wrap with occupancy kept in 0..3
    pulse_reset("rst6");
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 2);
      if (stk.size() == 0) begin
        p = 1'b1; q = 1'b0;
      end else if (stk.size() == 3) begin
        p = 1'b0; q = 1'b1;
      end else begin
        p = (r != 1);
        q = (r != 0);
      end
      do_cycle(p, q, 12'($urandom_range(1, 4095)), 1'b0);
    end
    do_cycle(0, 0, 12'h000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
